// File: rtl/prob_scheduler_if.sv
// ---------------------------------------------------------------------------
// prob_scheduler_if
// Bundles the request/decision handshake and the probability-unit operand
// and result signals of prob_scheduler.
//   master : requester plus probability unit (drives costs and pc results)
//   slave  : the scheduler itself
// Signals:
//   req_valid/req_ready     candidate cost pair handshake
//   new_cost/old_cost       candidate and current tour cost, unsigned
//   dec_valid/dec_accept    one-cycle decision strobe and verdict
//   pc_new/pc_old/pc_tinv   operands presented to the probability unit
//   pc_inp_valid            one-cycle start pulse to the probability unit
//   pc_out/pc_out_valid     probability (bits 23:0 fraction) and its strobe
// ---------------------------------------------------------------------------
interface prob_scheduler_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] new_cost;
   logic [31:0] old_cost;
   logic        dec_valid;
   logic        dec_accept;
   logic [31:0] pc_new;
   logic [31:0] pc_old;
   logic [31:0] pc_tinv;
   logic        pc_inp_valid;
   logic [31:0] pc_out;
   logic        pc_out_valid;

   modport master (
      output req_valid, new_cost, old_cost, pc_out, pc_out_valid,
      input  req_ready, dec_valid, dec_accept, pc_new, pc_old, pc_tinv, pc_inp_valid
   );

   modport slave (
      input  req_valid, new_cost, old_cost, pc_out, pc_out_valid,
      output req_ready, dec_valid, dec_accept, pc_new, pc_old, pc_tinv, pc_inp_valid
   );
endinterface

// File: rtl/prob_scheduler.sv
// ---------------------------------------------------------------------------
// prob_scheduler
// Simulated-annealing accept/reject scheduler. Improving or equal candidates
// are accepted directly; worse candidates are sent to an external probability
// unit and accepted when a free-running LFSR draw falls below the returned
// probability. The inverse temperature rises by a fixed bit-pattern step
// every ITERS_PER_STEP decisions until it saturates at TINV_MAX.
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   bus          prob_scheduler_if.slave (handshake, operands, results)
//   tinv         current inverse temperature
//   frozen       high while tinv == TINV_MAX
//   err_timeout  sticky, set when the probability unit fails to answer
// Timing: every state acts on the edge that leaves it, so dec_valid rises
// one edge after the capture edge (improving path) or one edge after the
// edge that samples pc_out_valid, and stays high for one cycle.
// ---------------------------------------------------------------------------
module prob_scheduler #(
   parameter logic [31:0] SEED           = 32'hACE1_2468,
   parameter logic [31:0] TINV_INIT      = 32'h3C23_D70A,
   parameter logic [31:0] TINV_STEP      = 32'h0000_0400,
   parameter logic [31:0] TINV_MAX       = 32'h4120_0000,
   parameter int unsigned ITERS_PER_STEP = 256,
   parameter int unsigned TIMEOUT        = 1023
) (
   input  logic                   clk,
   input  logic                   rst,
   prob_scheduler_if.slave        bus,
   output logic [31:0]            tinv,
   output logic                   frozen,
   output logic                   err_timeout
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DECIDE
   } state_t;

   localparam logic [15:0] ITER_LAST = 16'(ITERS_PER_STEP - 1);
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   state_t      state;
   logic [31:0] lfsr;
   logic [15:0] iter_cnt;
   logic [15:0] wait_cnt;
   logic        accept;

   logic        lfsr_fb;
   logic [31:0] lfsr_draw;
   logic [32:0] tinv_sum;
   logic [31:0] tinv_next;

   // Fibonacci taps 32,22,2,1 (bit numbers counted from 1).
   assign lfsr_fb   = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];
   // Random fraction in the same 8.24 format as pc_out.
   assign lfsr_draw = {8'b0, lfsr[23:0]};

   // NOTE: every variable assigned in always_comb gets a value on every path,
   // otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      tinv_sum  = {1'b0, tinv} + {1'b0, TINV_STEP};
      tinv_next = tinv_sum[31:0];
      // The 33-bit sum catches both overshoot and 32-bit wrap.
      if (tinv_sum >= {1'b0, TINV_MAX}) begin
         tinv_next = TINV_MAX;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= SEED;
      end else begin
         lfsr <= {lfsr[30:0], lfsr_fb};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= S_IDLE;
         bus.req_ready    <= 1'b1;
         bus.dec_valid    <= 1'b0;
         bus.dec_accept   <= 1'b0;
         bus.pc_inp_valid <= 1'b0;
         bus.pc_new       <= '0;
         bus.pc_old       <= '0;
         bus.pc_tinv      <= '0;
         accept           <= 1'b0;
         wait_cnt         <= '0;
         iter_cnt         <= '0;
         tinv             <= TINV_INIT;
         frozen           <= (TINV_INIT == TINV_MAX);
         err_timeout      <= 1'b0;
      end else begin
         // Strobes default low so each is a single-cycle pulse.
         bus.dec_valid    <= 1'b0;
         bus.dec_accept   <= 1'b0;
         bus.pc_inp_valid <= 1'b0;

         case (state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  // Operands stay on pc_* until the next capture; tinv is
                  // snapshotted here so a later step cannot affect this request.
                  bus.pc_new    <= bus.new_cost;
                  bus.pc_old    <= bus.old_cost;
                  bus.pc_tinv   <= tinv;
                  bus.req_ready <= 1'b0;
                  if (bus.new_cost <= bus.old_cost) begin
                     accept <= 1'b1;
                     state  <= S_DECIDE;
                  end else begin
                     state  <= S_ISSUE;
                  end
               end
            end

            S_ISSUE: begin
               bus.pc_inp_valid <= 1'b1;
               wait_cnt         <= '0;
               state            <= S_WAIT;
            end

            S_WAIT: begin
               // A result arriving in the final WAIT cycle wins over timeout.
               if (bus.pc_out_valid) begin
                  accept <= (lfsr_draw < bus.pc_out);
                  state  <= S_DECIDE;
               end else if (wait_cnt == WAIT_LAST) begin
                  accept      <= 1'b0;
                  err_timeout <= 1'b1;
                  state       <= S_DECIDE;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end

            S_DECIDE: begin
               bus.dec_valid  <= 1'b1;
               bus.dec_accept <= accept;
               bus.req_ready  <= 1'b1;
               state          <= S_IDLE;
               if (iter_cnt == ITER_LAST) begin
                  iter_cnt <= '0;
                  tinv     <= tinv_next;
                  frozen   <= (tinv_next == TINV_MAX);
               end else begin
                  iter_cnt <= iter_cnt + 16'd1;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prob_scheduler.sv
// ---------------------------------------------------------------------------
// tb_prob_scheduler
// Directed bench for prob_scheduler. dut_a uses default parameters; dut_b
// uses a short timeout and a tiny temperature schedule (TIMEOUT=8,
// ITERS_PER_STEP=2, TINV_INIT=0, TINV_STEP=5, TINV_MAX=12). Both share
// clk/rst. Outputs are sampled 1 ns after each rising edge, and inputs are
// changed at the same point.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_prob_scheduler;

   localparam logic [31:0] A_SEED = 32'hACE1_2468;
   localparam logic [31:0] A_INIT = 32'h3C23_D70A;
   localparam logic [31:0] A_STEP = 32'h0000_0400;
   localparam int          B_TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] tinv_a, tinv_b;
   logic        frozen_a, frozen_b, err_a, err_b;

   int n_cmp = 0;
   int n_bad = 0;
   int dec_cnt_a = 0;

   // Reference LFSR: 32-bit Fibonacci, taps 32,22,2,1, free-running from seed.
   logic [31:0] model_lfsr;

   always #5 clk = ~clk;

   prob_scheduler_if bus_a ();
   prob_scheduler_if bus_b ();

   prob_scheduler dut_a (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus_a),
      .tinv        (tinv_a),
      .frozen      (frozen_a),
      .err_timeout (err_a)
   );

   prob_scheduler #(
      .TINV_INIT      (32'd0),
      .TINV_STEP      (32'd5),
      .TINV_MAX       (32'd12),
      .ITERS_PER_STEP (2),
      .TIMEOUT        (B_TIMEOUT)
   ) dut_b (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus_b),
      .tinv        (tinv_b),
      .frozen      (frozen_b),
      .err_timeout (err_b)
   );

   always @(posedge clk or posedge rst) begin
      if (rst) model_lfsr <= A_SEED;
      else     model_lfsr <= {model_lfsr[30:0],
                              model_lfsr[31] ^ model_lfsr[21] ^ model_lfsr[1] ^ model_lfsr[0]};
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Improving/equal request on dut_a; reports pc_inp_valid pulses seen and
   // the edge index (0 = capture edge + 1 edge) at which dec_valid is high.
   task automatic fast_txn_a(input logic [31:0] nc, input logic [31:0] oc,
                             output int n_inp, output int lat, output logic acc);
      n_inp = 0; lat = -1; acc = 1'bx;
      bus_a.new_cost = nc; bus_a.old_cost = oc; bus_a.req_valid = 1'b1;
      tick;
      bus_a.req_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (bus_a.pc_inp_valid) n_inp++;
         if (bus_a.dec_valid && lat < 0) begin lat = i; acc = bus_a.dec_accept; dec_cnt_a++; end
         tick;
      end
   endtask

   task automatic fast_txn_b(input logic [31:0] nc, input logic [31:0] oc,
                             output int lat, output logic acc);
      lat = -1; acc = 1'bx;
      bus_b.new_cost = nc; bus_b.old_cost = oc; bus_b.req_valid = 1'b1;
      tick;
      bus_b.req_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (bus_b.dec_valid && lat < 0) begin lat = i; acc = bus_b.dec_accept; end
         tick;
      end
   endtask

   // Worsening request on dut_a; pc_out_valid is returned `gap` cycles after
   // the capture edge (gap >= 1 so the FSM is already in WAIT). lat is the
   // number of edges after the pc_out_valid sampling edge where dec_valid is
   // first seen high; exp_acc comes from the reference LFSR.
   task automatic prob_txn_a(input logic [31:0] nc, input logic [31:0] oc, input int gap,
                             input logic [31:0] pco,
                             output int n_inp, output logic [31:0] s_new, output logic [31:0] s_old,
                             output logic [31:0] s_tinv, output int early, output int lat,
                             output logic acc, output logic exp_acc);
      n_inp = 0; early = 0; lat = -1; acc = 1'bx;
      s_new = '0; s_old = '0; s_tinv = '0;
      bus_a.new_cost = nc; bus_a.old_cost = oc; bus_a.req_valid = 1'b1;
      tick;
      bus_a.req_valid = 1'b0;
      if (bus_a.pc_inp_valid) n_inp++;
      for (int i = 0; i < gap; i++) begin
         tick;
         if (bus_a.pc_inp_valid) begin
            n_inp++; s_new = bus_a.pc_new; s_old = bus_a.pc_old; s_tinv = bus_a.pc_tinv;
         end
         if (bus_a.dec_valid) early++;
      end
      bus_a.pc_out = pco; bus_a.pc_out_valid = 1'b1;
      exp_acc = ({8'b0, model_lfsr[23:0]} < pco);
      tick;
      bus_a.pc_out_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (bus_a.pc_inp_valid) n_inp++;
         if (bus_a.dec_valid && lat < 0) begin lat = i; acc = bus_a.dec_accept; dec_cnt_a++; end
         tick;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      dec_cnt_a = 0;
      if (bus_a.req_ready !== 1'b1) begin $display("FAIL reset_req_ready: got %b want 1", bus_a.req_ready); n_bad++; end n_cmp++;
      if (bus_a.dec_valid !== 1'b0) begin $display("FAIL reset_dec_valid: got %b want 0", bus_a.dec_valid); n_bad++; end n_cmp++;
      if (bus_a.dec_accept !== 1'b0) begin $display("FAIL reset_dec_accept: got %b want 0", bus_a.dec_accept); n_bad++; end n_cmp++;
      if (bus_a.pc_inp_valid !== 1'b0) begin $display("FAIL reset_pc_inp_valid: got %b want 0", bus_a.pc_inp_valid); n_bad++; end n_cmp++;
      if (bus_a.pc_new !== 32'd0) begin $display("FAIL reset_pc_new: got %h want 0", bus_a.pc_new); n_bad++; end n_cmp++;
      if (bus_a.pc_old !== 32'd0) begin $display("FAIL reset_pc_old: got %h want 0", bus_a.pc_old); n_bad++; end n_cmp++;
      if (bus_a.pc_tinv !== 32'd0) begin $display("FAIL reset_pc_tinv: got %h want 0", bus_a.pc_tinv); n_bad++; end n_cmp++;
      if (tinv_a !== A_INIT) begin $display("FAIL reset_tinv_a: got %h want %h", tinv_a, A_INIT); n_bad++; end n_cmp++;
      if (frozen_a !== 1'b0) begin $display("FAIL reset_frozen_a: got %b want 0", frozen_a); n_bad++; end n_cmp++;
      if (err_a !== 1'b0) begin $display("FAIL reset_err_a: got %b want 0", err_a); n_bad++; end n_cmp++;
      if (tinv_b !== 32'd0) begin $display("FAIL reset_tinv_b: got %h want 0", tinv_b); n_bad++; end n_cmp++;
      if (frozen_b !== 1'b0) begin $display("FAIL reset_frozen_b: got %b want 0", frozen_b); n_bad++; end n_cmp++;
      tick;
      if (bus_a.req_ready !== 1'b1) begin $display("FAIL reset_idle_ready: got %b want 1", bus_a.req_ready); n_bad++; end n_cmp++;
   endtask

   // new=100 < old=200: no probability request, dec_valid rises one edge
   // after the capture edge (sampled high at the second edge).
   task automatic test_improving;
      int n_inp, lat; logic acc;
      fast_txn_a(32'd100, 32'd200, n_inp, lat, acc);
      if (n_inp !== 0) begin $display("FAIL improving_no_pc: got %0d pulses want 0", n_inp); n_bad++; end n_cmp++;
      if (lat !== 1) begin $display("FAIL improving_latency: got %0d want 1", lat); n_bad++; end n_cmp++;
      if (acc !== 1'b1) begin $display("FAIL improving_accept: got %b want 1", acc); n_bad++; end n_cmp++;
      if (bus_a.pc_new !== 32'd100 || bus_a.pc_old !== 32'd200) begin
         $display("FAIL improving_operands: got %0d/%0d want 100/200", bus_a.pc_new, bus_a.pc_old); n_bad++;
      end n_cmp++;
      if (bus_a.req_ready !== 1'b1) begin $display("FAIL improving_ready: got %b want 1", bus_a.req_ready); n_bad++; end n_cmp++;
   endtask

   task automatic test_equal;
      int n_inp, lat; logic acc;
      fast_txn_a(32'd150, 32'd150, n_inp, lat, acc);
      if (n_inp !== 0) begin $display("FAIL equal_no_pc: got %0d pulses want 0", n_inp); n_bad++; end n_cmp++;
      if (lat !== 1) begin $display("FAIL equal_latency: got %0d want 1", lat); n_bad++; end n_cmp++;
      if (acc !== 1'b1) begin $display("FAIL equal_accept: got %b want 1", acc); n_bad++; end n_cmp++;
   endtask

   task automatic test_prob_accept;
      int n_inp, early, lat; logic acc, exp_acc; logic [31:0] s_new, s_old, s_tinv;
      prob_txn_a(32'd300, 32'd200, 20, 32'h00FF_FFFF, n_inp, s_new, s_old, s_tinv, early, lat, acc, exp_acc);
      if (n_inp !== 1) begin $display("FAIL prob_one_pulse: got %0d want 1", n_inp); n_bad++; end n_cmp++;
      if (s_new !== 32'd300 || s_old !== 32'd200) begin
         $display("FAIL prob_operands: got %0d/%0d want 300/200", s_new, s_old); n_bad++;
      end n_cmp++;
      if (s_tinv !== A_INIT) begin $display("FAIL prob_tinv: got %h want %h", s_tinv, A_INIT); n_bad++; end n_cmp++;
      if (early !== 0) begin $display("FAIL prob_early_dec: got %0d want 0", early); n_bad++; end n_cmp++;
      if (lat !== 1) begin $display("FAIL prob_latency: got %0d want 1", lat); n_bad++; end n_cmp++;
      if (acc !== 1'b1) begin $display("FAIL prob_accept_ffffff: got %b want 1", acc); n_bad++; end n_cmp++;
   endtask

   task automatic test_prob_reject;
      int n_inp, early, lat; logic acc, exp_acc; logic [31:0] s_new, s_old, s_tinv;
      prob_txn_a(32'd300, 32'd200, 5, 32'd0, n_inp, s_new, s_old, s_tinv, early, lat, acc, exp_acc);
      if (lat !== 1) begin $display("FAIL reject_latency: got %0d want 1", lat); n_bad++; end n_cmp++;
      if (acc !== 1'b0) begin $display("FAIL reject_zero_prob: got %b want 0", acc); n_bad++; end n_cmp++;
      // Probability 1.0 exceeds every 24-bit draw.
      prob_txn_a(32'd999, 32'd1, 2, 32'h0100_0000, n_inp, s_new, s_old, s_tinv, early, lat, acc, exp_acc);
      if (acc !== 1'b1) begin $display("FAIL accept_unity_prob: got %b want 1", acc); n_bad++; end n_cmp++;
   endtask

   // Probability 0.5 with several gaps: verdict follows the reference LFSR.
   task automatic test_prob_lfsr;
      int gaps [4] = '{1, 3, 7, 12};
      int n_inp, early, lat; logic acc, exp_acc; logic [31:0] s_new, s_old, s_tinv;
      foreach (gaps[k]) begin
         prob_txn_a(32'd500, 32'd400, gaps[k], 32'h0080_0000, n_inp, s_new, s_old, s_tinv, early, lat, acc, exp_acc);
         if (acc !== exp_acc) begin $display("FAIL lfsr_verdict gap=%0d: got %b want %b", gaps[k], acc, exp_acc); n_bad++; end n_cmp++;
         if (n_inp !== 1) begin $display("FAIL lfsr_pulse gap=%0d: got %0d want 1", gaps[k], n_inp); n_bad++; end n_cmp++;
      end
   endtask

   task automatic test_stray_valid;
      int n_dec = 0;
      bus_a.pc_out = 32'h0100_0000; bus_a.pc_out_valid = 1'b1;
      tick; tick;
      bus_a.pc_out_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (bus_a.dec_valid) n_dec++;
         tick;
      end
      if (n_dec !== 0) begin $display("FAIL stray_dec: got %0d want 0", n_dec); n_bad++; end n_cmp++;
      if (bus_a.req_ready !== 1'b1) begin $display("FAIL stray_ready: got %b want 1", bus_a.req_ready); n_bad++; end n_cmp++;
   endtask

   // req_valid held high: second capture happens on the edge after dec_valid rises.
   task automatic test_back_to_back;
      bus_a.new_cost = 32'd100; bus_a.old_cost = 32'd200; bus_a.req_valid = 1'b1;
      tick;
      bus_a.new_cost = 32'd50; bus_a.old_cost = 32'd60;
      if (bus_a.req_ready !== 1'b0) begin $display("FAIL b2b_busy: got %b want 0", bus_a.req_ready); n_bad++; end n_cmp++;
      tick;
      if (bus_a.dec_valid !== 1'b1 || bus_a.req_ready !== 1'b1) begin
         $display("FAIL b2b_first_dec: got dec=%b ready=%b want 1/1", bus_a.dec_valid, bus_a.req_ready); n_bad++;
      end n_cmp++;
      tick;
      bus_a.req_valid = 1'b0;
      if (bus_a.pc_new !== 32'd50 || bus_a.dec_valid !== 1'b0) begin
         $display("FAIL b2b_second_capture: got pc_new=%0d dec=%b want 50/0", bus_a.pc_new, bus_a.dec_valid); n_bad++;
      end n_cmp++;
      tick;
      if (bus_a.dec_valid !== 1'b1 || bus_a.dec_accept !== 1'b1) begin
         $display("FAIL b2b_second_dec: got dec=%b acc=%b want 1/1", bus_a.dec_valid, bus_a.dec_accept); n_bad++;
      end n_cmp++;
      dec_cnt_a += 2;
      tick;
   endtask

   // Default schedule: tinv steps once after the 256th decision.
   task automatic test_step_a;
      int n_inp, lat; logic acc;
      int early; logic exp_acc; logic [31:0] s_new, s_old, s_tinv;
      for (int k = 0; k < 300 && dec_cnt_a < 255; k++) fast_txn_a(32'd1, 32'd2, n_inp, lat, acc);
      if (tinv_a !== A_INIT) begin $display("FAIL step_before: got %h want %h", tinv_a, A_INIT); n_bad++; end n_cmp++;
      fast_txn_a(32'd1, 32'd2, n_inp, lat, acc);
      if (tinv_a !== A_INIT + A_STEP) begin $display("FAIL step_after: got %h want %h", tinv_a, A_INIT + A_STEP); n_bad++; end n_cmp++;
      if (frozen_a !== 1'b0) begin $display("FAIL step_frozen: got %b want 0", frozen_a); n_bad++; end n_cmp++;
      prob_txn_a(32'd300, 32'd200, 3, 32'd0, n_inp, s_new, s_old, s_tinv, early, lat, acc, exp_acc);
      if (s_tinv !== A_INIT + A_STEP) begin $display("FAIL step_pc_tinv: got %h want %h", s_tinv, A_INIT + A_STEP); n_bad++; end n_cmp++;
   endtask

   // dut_b: tinv 0 -> 5 -> 10 -> 12 (saturated) every two decisions.
   task automatic test_tinv_b;
      logic [31:0] exp_t [8] = '{32'd0, 32'd5, 32'd5, 32'd10, 32'd10, 32'd12, 32'd12, 32'd12};
      logic        exp_f [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      int lat; logic acc;
      foreach (exp_t[k]) begin
         fast_txn_b(32'd7, 32'd9, lat, acc);
         if (tinv_b !== exp_t[k]) begin $display("FAIL tinv_b dec=%0d: got %0d want %0d", k + 1, tinv_b, exp_t[k]); n_bad++; end n_cmp++;
         if (frozen_b !== exp_f[k]) begin $display("FAIL frozen_b dec=%0d: got %b want %b", k + 1, frozen_b, exp_f[k]); n_bad++; end n_cmp++;
      end
   endtask

   // One ISSUE cycle, 8 WAIT cycles: err_timeout rises on edge 9 after
   // capture and dec_valid on edge 10.
   task automatic test_timeout_b;
      int lat = -1, err_at = -1, n_inp = 0; logic acc = 1'bx;
      bus_b.new_cost = 32'd300; bus_b.old_cost = 32'd200; bus_b.req_valid = 1'b1;
      @(posedge clk); #1;
      bus_b.req_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus_b.pc_inp_valid) n_inp++;
         if (err_b && err_at < 0) err_at = i;
         if (bus_b.dec_valid && lat < 0) begin lat = i; acc = bus_b.dec_accept; end
         @(posedge clk); #1;
      end
      if (n_inp !== 1) begin $display("FAIL timeout_pulse: got %0d want 1", n_inp); n_bad++; end n_cmp++;
      if (err_at !== B_TIMEOUT + 1) begin $display("FAIL timeout_err_edge: got %0d want %0d", err_at, B_TIMEOUT + 1); n_bad++; end n_cmp++;
      if (lat !== B_TIMEOUT + 2) begin $display("FAIL timeout_dec_edge: got %0d want %0d", lat, B_TIMEOUT + 2); n_bad++; end n_cmp++;
      if (acc !== 1'b0) begin $display("FAIL timeout_accept: got %b want 0", acc); n_bad++; end n_cmp++;
      fast_txn_b(32'd1, 32'd2, lat, acc);
      if (err_b !== 1'b1) begin $display("FAIL timeout_sticky: got %b want 1", err_b); n_bad++; end n_cmp++;
      if (acc !== 1'b1) begin $display("FAIL timeout_next_accept: got %b want 1", acc); n_bad++; end n_cmp++;
   endtask

   task automatic test_reset_mid_wait;
      int n_dec = 0;
      bus_a.new_cost = 32'd300; bus_a.old_cost = 32'd200; bus_a.req_valid = 1'b1;
      tick;
      bus_a.req_valid = 1'b0;
      tick; tick;
      #2 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      if (bus_a.req_ready !== 1'b1) begin $display("FAIL rstwait_ready: got %b want 1", bus_a.req_ready); n_bad++; end n_cmp++;
      if (tinv_a !== A_INIT) begin $display("FAIL rstwait_tinv_a: got %h want %h", tinv_a, A_INIT); n_bad++; end n_cmp++;
      if (bus_a.pc_new !== 32'd0) begin $display("FAIL rstwait_pc_new: got %h want 0", bus_a.pc_new); n_bad++; end n_cmp++;
      if (err_b !== 1'b0 || tinv_b !== 32'd0 || frozen_b !== 1'b0) begin
         $display("FAIL rstwait_b: got err=%b tinv=%0d frozen=%b want 0/0/0", err_b, tinv_b, frozen_b); n_bad++;
      end n_cmp++;
      bus_a.pc_out = 32'h0100_0000; bus_a.pc_out_valid = 1'b1;
      tick;
      bus_a.pc_out_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (bus_a.dec_valid) n_dec++;
         tick;
      end
      if (n_dec !== 0) begin $display("FAIL rstwait_no_dec: got %0d want 0", n_dec); n_bad++; end n_cmp++;
      if (bus_a.req_ready !== 1'b1) begin $display("FAIL rstwait_idle: got %b want 1", bus_a.req_ready); n_bad++; end n_cmp++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      bus_a.req_valid = 1'b0; bus_a.new_cost = '0; bus_a.old_cost = '0;
      bus_a.pc_out = '0; bus_a.pc_out_valid = 1'b0;
      bus_b.req_valid = 1'b0; bus_b.new_cost = '0; bus_b.old_cost = '0;
      bus_b.pc_out = '0; bus_b.pc_out_valid = 1'b0;

      test_reset();
      test_improving();
      test_equal();
      test_prob_accept();
      test_prob_reject();
      test_prob_lfsr();
      test_stray_valid();
      test_back_to_back();
      test_step_a();
      test_tinv_b();
      test_timeout_b();
      test_reset_mid_wait();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/prob_scheduler.md
PROB_SCHEDULER -- requirements
Module: prob_scheduler

Interface
REQ-001 Parameter SEED, default 32'hACE1_2468, nonzero LFSR reset value.
REQ-002 Parameter TINV_INIT, default 32'h3C23_D70A (float 0.01), initial inverse temperature.
REQ-003 Parameter TINV_STEP, default 32'h0000_0400, integer added to tinv bit pattern per temperature step.
REQ-004 Parameter TINV_MAX, default 32'h4120_0000 (float 10.0), tinv saturation value.
REQ-005 Parameter ITERS_PER_STEP, default 256, decisions per temperature step, range 1..65535.
REQ-006 Parameter TIMEOUT, default 1023, max WAIT cycles, range 1..65535.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst  in  1  reset; asynchronous, active-high.
REQ-009 req_valid  in  1  candidate tour cost pair offered.
REQ-010 req_ready  out  1  high only in IDLE.
REQ-011 new_cost  in  32  candidate cost, unsigned.
REQ-012 old_cost  in  32  current cost, unsigned.
REQ-013 dec_valid  out  1  one-cycle decision strobe.
REQ-014 dec_accept  out  1  1 = accept candidate; qualified by dec_valid.
REQ-015 pc_new, pc_old, pc_tinv  out  32 each  operands to probability unit.
REQ-016 pc_inp_valid  out  1  one-cycle start pulse to probability unit.
REQ-017 pc_out  in  32  probability, fixed point, bits 23:0 fraction.
REQ-018 pc_out_valid  in  1  probability result strobe.
REQ-019 tinv  out  32  current inverse temperature.
REQ-020 frozen  out  1  high when tinv == TINV_MAX.
REQ-021 err_timeout  out  1  sticky; set on WAIT timeout.

Function
REQ-022 FSM states IDLE, ISSUE, WAIT, DECIDE; all outputs registered.
REQ-023 IDLE: req_valid=1 captures new_cost/old_cost/tinv into operand registers; next state DECIDE with accept=1 if new_cost <= old_cost, else ISSUE.
REQ-024 ISSUE: pc_inp_valid=1 for exactly one cycle, pc_new/pc_old/pc_tinv = captured operands (held stable until next capture); next WAIT.
REQ-025 WAIT: on pc_out_valid, accept = ({8'b0, lfsr[23:0]} < pc_out), next DECIDE; pc_out_valid outside WAIT ignored.
REQ-026 WAIT: wait counter increments per cycle; reaching TIMEOUT without pc_out_valid gives accept=0, err_timeout=1, next DECIDE.
REQ-027 DECIDE: dec_valid=1, dec_accept=accept for one cycle; next IDLE.
REQ-028 Latency: improving candidate: dec_valid 2 cycles after capture edge; otherwise 1 cycle after pc_out_valid edge.
REQ-029 LFSR 32-bit Fibonacci, taps 32,22,2,1, shifts every cycle, free-running.
REQ-030 Each DECIDE increments iter counter; at ITERS_PER_STEP-1 it wraps to 0 and tinv += TINV_STEP, saturating at TINV_MAX (no overshoot, no wrap).
REQ-031 tinv change takes effect for the next capture only; in-flight operands unchanged.
REQ-032 Equal costs (new_cost == old_cost) SHALL be accepted without using the probability unit.

Reset
REQ-033 rst=1 forces IDLE, req_ready=1 after release, dec_valid=0, dec_accept=0, pc_inp_valid=0, pc_* operands=0, tinv=TINV_INIT, iter and wait counters=0, lfsr=SEED, err_timeout=0, frozen=(TINV_INIT==TINV_MAX).
REQ-034 rst asserted in WAIT abandons the request with no dec_valid; a late pc_out_valid after release SHALL be ignored.

Verification
REQ-035 new=100, old=200 -> no pc_inp_valid, dec_valid with dec_accept=1 two cycles after capture.
REQ-036 new=300, old=200 -> one pc_inp_valid with pc_new=300, pc_old=200, pc_tinv=TINV_INIT; pc_out=32'h00FF_FFFF after 20 cycles -> dec_accept=1; pc_out=0 -> dec_accept=0.
REQ-037 No pc_out_valid with TIMEOUT=8 -> dec_valid, dec_accept=0 after 8 WAIT cycles, err_timeout stays 1 until rst.
REQ-038 ITERS_PER_STEP=2, TINV_INIT=0, TINV_STEP=5, TINV_MAX=12 -> tinv 0,5,10,12 after 2,4,6 decisions; frozen=1 at 12 and held.
REQ-039 rst mid-WAIT then stray pc_out_valid -> no dec_valid, req_ready=1, tinv=TINV_INIT.
